// File: rtl/serial_bit_subtractor.sv
// LSB-first bit-serial subtractor: d = x - y - bi (mod 2^WIDTH), one bit per clock.
// Optional signed-overflow output ovf is enabled by defining SERIAL_SUB_OVF_EN.
module serial_bit_subtractor #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             bi,
  input  logic             sub,
  output logic [WIDTH-1:0] d,
  output logic             bo,
  output logic             busy,
  output logic             done
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   xs_q, xs_d;
  logic [WIDTH-1:0]   ys_q, ys_d;
  logic [WIDTH-1:0]   ds_q, ds_d;
  logic               borrow_q, borrow_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   d_q, d_d;
  logic               bo_q, bo_d;
  logic               done_q, done_d;
  logic               dbit;
`ifdef SERIAL_SUB_OVF_EN
  logic               xmsb_q, xmsb_d;
  logic               ymsb_q, ymsb_d;
  logic               ovf_q, ovf_d;
`endif

  always_comb begin
    state_d  = state_q;
    xs_d     = xs_q;
    ys_d     = ys_q;
    ds_d     = ds_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    d_d      = d_q;
    bo_d     = bo_q;
    done_d   = 1'b0;
    dbit     = xs_q[0] ^ ys_q[0] ^ borrow_q;
`ifdef SERIAL_SUB_OVF_EN
    xmsb_d   = xmsb_q;
    ymsb_d   = ymsb_q;
    ovf_d    = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (sub) begin
          xs_d     = x;
          ys_d     = y;
          borrow_d = bi;
          cnt_d    = '0;
          state_d  = SHIFT;
`ifdef SERIAL_SUB_OVF_EN
          xmsb_d   = x[WIDTH-1];
          ymsb_d   = y[WIDTH-1];
`endif
        end
      end
      SHIFT: begin
        // Full-subtractor borrow: borrow out when x<y, or x==y with a pending borrow.
        borrow_d = (~xs_q[0] & ys_q[0]) | (~(xs_q[0] ^ ys_q[0]) & borrow_q);
        xs_d     = xs_q >> 1;
        ys_d     = ys_q >> 1;
        ds_d     = {dbit, ds_q[WIDTH-1:1]};
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        d_d     = ds_q;
        bo_d    = borrow_q;
        done_d  = 1'b1;
        state_d = IDLE;
`ifdef SERIAL_SUB_OVF_EN
        ovf_d   = (xmsb_q ^ ymsb_q) & (xmsb_q ^ ds_q[WIDTH-1]);
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      xs_q     <= '0;
      ys_q     <= '0;
      ds_q     <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      d_q      <= '0;
      bo_q     <= 1'b0;
      done_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      xmsb_q   <= 1'b0;
      ymsb_q   <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      xs_q     <= xs_d;
      ys_q     <= ys_d;
      ds_q     <= ds_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      d_q      <= d_d;
      bo_q     <= bo_d;
      done_q   <= done_d;
`ifdef SERIAL_SUB_OVF_EN
      xmsb_q   <= xmsb_d;
      ymsb_q   <= ymsb_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign d    = d_q;
  assign bo   = bo_q;
  assign done = done_q;
  assign busy = (state_q != IDLE);
`ifdef SERIAL_SUB_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_bit_subtractor.sv
// Directed self-checking bench for serial_bit_subtractor (WIDTH=8).
module tb_serial_bit_subtractor;

  logic       clk;
  logic       rst;
  logic [7:0] x;
  logic [7:0] y;
  logic       bi;
  logic       sub;
  logic [7:0] d;
  logic       bo;
  logic       busy;
  logic       done;
`ifdef SERIAL_SUB_OVF_EN
  logic       ovf;
`endif

  int checks = 0;
  int errors = 0;

  serial_bit_subtractor #(.WIDTH(8), .CNT_W(5)) dut (
    .clk  (clk),
    .rst  (rst),
    .x    (x),
    .y    (y),
    .bi   (bi),
    .sub  (sub),
    .d    (d),
    .bo   (bo),
    .busy (busy),
    .done (done)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf  (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pulse sub for one edge, then wait (bounded) for done; lat = edges after start edge.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input bit disturb, output int lat, output int busy_cnt);
    x = a; y = b; bi = c; sub = 1'b1;
    @(posedge clk); #1;
    sub = 1'b0;
    lat = 0;
    busy_cnt = busy ? 1 : 0;
    while (!done && lat < 30) begin
      @(posedge clk); #1;
      lat++;
      if (disturb && lat == 3) begin
        x = 8'h12; y = 8'h34; bi = 1'b1; sub = 1'b1;
      end
      if (disturb && lat == 5) sub = 1'b0;
      if (busy) busy_cnt++;
    end
  endtask

  int lat, bc;
  int done_at[$];

  initial begin
    rst = 1'b1; x = '0; y = '0; bi = 1'b0; sub = 1'b0;
    #12;
    check("rst_d", d, 0);
    check("rst_bo", bo, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
`ifdef SERIAL_SUB_OVF_EN
    check("rst_ovf", ovf, 0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(8'h05, 8'h03, 1'b0, 1'b0, lat, bc);
    check("lat_5m3", lat, 9);
    check("busy_cycles", bc, 9);
    check("d_5m3", d, 8'h02);
    check("bo_5m3", bo, 0);
`ifdef SERIAL_SUB_OVF_EN
    check("ovf_5m3", ovf, 0);
`endif
    @(posedge clk); #1;
    check("done_one_cycle", done, 0);
    check("d_hold", d, 8'h02);

    run_op(8'h03, 8'h05, 1'b0, 1'b0, lat, bc);
    check("d_3m5", d, 8'hFE);
    check("bo_3m5", bo, 1);

    run_op(8'h00, 8'h00, 1'b1, 1'b0, lat, bc);
    check("d_0m0b", d, 8'hFF);
    check("bo_0m0b", bo, 1);

    run_op(8'hFF, 8'hFF, 1'b0, 1'b1, lat, bc);
    check("lat_disturb", lat, 9);
    check("d_ffmff", d, 8'h00);
    check("bo_ffmff", bo, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Held sub: three back-to-back operations.
    x = 8'h10; y = 8'h01; bi = 1'b0; sub = 1'b1;
    @(posedge clk); #1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done) begin
        done_at.push_back(i);
        check("d_b2b", d, 8'h0F);
        check("bo_b2b", bo, 0);
        if (done_at.size() == 3) sub = 1'b0;
      end
    end
    check("b2b_count", done_at.size(), 3);
    if (done_at.size() == 3) begin
      check("b2b_first", done_at[0], 9);
      check("b2b_gap1", done_at[1] - done_at[0], 10);
      check("b2b_gap2", done_at[2] - done_at[1], 10);
    end
    check("b2b_idle", busy, 0);

    // Abort mid-SHIFT with an asynchronous reset pulse.
    x = 8'h40; y = 8'h01; bi = 1'b0; sub = 1'b1;
    @(posedge clk); #1;
    sub = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("busy_pre_rst", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_d", d, 0);
    check("arst_bo", bo, 0);
    check("arst_busy", busy, 0);
    #1 rst = 1'b0;
    bc = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (done) bc++;
    end
    check("no_done_after_abort", bc, 0);

    run_op(8'h20, 8'h10, 1'b0, 1'b0, lat, bc);
    check("lat_after_rst", lat, 9);
    check("d_20m10", d, 8'h10);
    check("bo_20m10", bo, 0);

`ifdef SERIAL_SUB_OVF_EN
    run_op(8'h80, 8'h01, 1'b0, 1'b0, lat, bc);
    check("d_80m01", d, 8'h7F);
    check("bo_80m01", bo, 0);
    check("ovf_80m01", ovf, 1);
    run_op(8'h7F, 8'hFF, 1'b0, 1'b0, lat, bc);
    check("d_7fmff", d, 8'h80);
    check("bo_7fmff", bo, 1);
    check("ovf_7fmff", ovf, 1);
    run_op(8'h05, 8'h03, 1'b0, 1'b0, lat, bc);
    check("ovf_5m3b", ovf, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
